// File: rtl/keypad_code_entry_pkg.sv
// Shared constants, state encoding and key classification for the keypad
// code-entry front end.
package keypad_code_entry_pkg;

  localparam logic [3:0] KEY_CLR   = 4'hA;
  localparam logic [3:0] KEY_ENT   = 4'hB;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } state_t;

  typedef enum logic [1:0] {
    KC_DIGIT,
    KC_CLEAR,
    KC_ENTER,
    KC_ILLEGAL
  } key_class_t;

  function automatic key_class_t classify_key(input logic [3:0] key);
    key_class_t kc;
    if (key <= 4'd9)          kc = KC_DIGIT;
    else if (key == KEY_CLR)  kc = KC_CLEAR;
    else if (key == KEY_ENT)  kc = KC_ENTER;
    else                      kc = KC_ILLEGAL;
    return kc;
  endfunction

endpackage

// File: rtl/keypad_code_entry_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder (gfedcba order);
// values above 9 show the letter E.
module bcd_to_seg7
  import keypad_code_entry_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_ERR;
    unique case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/keypad_code_entry.sv
// Keypad code entry: assembles a two-digit BCD code from debounced keys and
// submits it to the lock with an ok strobe framed by setup and hold cycles.
module keypad_code_entry
  import keypad_code_entry_pkg::*;
#(
  parameter int unsigned OK_PULSE       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned TMR_W          = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] code,
  output logic       ok,
  output logic       busy,
  output logic [1:0] digit_cnt,
  output logic       err,
  output logic       timeout,
  output logic [6:0] seg1,
  output logic [6:0] seg2
);

  localparam int unsigned     PC_W       = (OK_PULSE > 1) ? $clog2(OK_PULSE) : 1;
  localparam logic [PC_W-1:0] PULSE_LAST = PC_W'(OK_PULSE - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  key_class_t       key_class;
  logic [TMR_W-1:0] timer;
  logic [PC_W-1:0]  pulse_cnt;
  logic [6:0]       seg_lo;
  logic [6:0]       seg_hi;

  always_comb key_class = classify_key(key_code);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      code      <= '0;
      ok        <= 1'b0;
      busy      <= 1'b0;
      digit_cnt <= '0;
      err       <= 1'b0;
      timeout   <= 1'b0;
      timer     <= '0;
      pulse_cnt <= '0;
    end else begin
      err     <= 1'b0;
      timeout <= 1'b0;
      unique case (state)
        ST_IDLE, ST_ENTRY: begin
          if (key_valid) begin
            // Any key, even one rejected, suppresses the timer for this cycle.
            unique case (key_class)
              KC_DIGIT: begin
                code  <= {code[3:0], key_code};
                timer <= '0;
                state <= ST_ENTRY;
                if (digit_cnt != 2'd2) digit_cnt <= digit_cnt + 2'd1;
              end
              KC_CLEAR: begin
                code      <= '0;
                digit_cnt <= '0;
                timer     <= '0;
                state     <= ST_IDLE;
              end
              KC_ENTER: begin
                if (digit_cnt == 2'd2) begin
                  busy  <= 1'b1;
                  timer <= '0;
                  state <= ST_SETUP;
                end else begin
                  err <= 1'b1;
                end
              end
              default: err <= 1'b1;
            endcase
          end else if (state == ST_ENTRY) begin
            if (timer == TMR_LAST) begin
              timeout   <= 1'b1;
              code      <= '0;
              digit_cnt <= '0;
              timer     <= '0;
              state     <= ST_IDLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        ST_SETUP: begin
          ok        <= 1'b1;
          pulse_cnt <= '0;
          state     <= ST_PULSE;
        end
        ST_PULSE: begin
          if (pulse_cnt == PULSE_LAST) begin
            ok    <= 1'b0;
            state <= ST_HOLD;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          busy      <= 1'b0;
          code      <= '0;
          digit_cnt <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bcd_to_seg7 u_seg_lo (
    .bcd (code[3:0]),
    .seg (seg_lo)
  );

  bcd_to_seg7 u_seg_hi (
    .bcd (code[7:4]),
    .seg (seg_hi)
  );

  // Positions not yet entered stay dark; the first digit appears on seg1.
  always_comb begin
    seg1 = (digit_cnt != 2'd0) ? seg_lo : SEG_BLANK;
    seg2 = (digit_cnt == 2'd2) ? seg_hi : SEG_BLANK;
  end

endmodule

// File: tb/tb_keypad_code_entry.sv
// Randomised bench for keypad_code_entry: a digit-list reference model predicts
// err/timeout/ok events into a queue that a negedge monitor drains.
module tb_keypad_code_entry;

  localparam int unsigned OK_PULSE       = 4;
  localparam int unsigned TIMEOUT_CYCLES = 10;
  localparam int unsigned TMR_W          = 8;

  localparam int EV_ERR = 0;
  localparam int EV_TMO = 1;
  localparam int EV_SUB = 2;

  typedef struct {
    int         kind;
    logic [7:0] code;
    int         at;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] code;
  logic       ok;
  logic       busy;
  logic [1:0] digit_cnt;
  logic       err;
  logic       timeout;
  logic [6:0] seg1;
  logic [6:0] seg2;

  keypad_code_entry #(
    .OK_PULSE       (OK_PULSE),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .code      (code),
    .ok        (ok),
    .busy      (busy),
    .digit_cnt (digit_cnt),
    .err       (err),
    .timeout   (timeout),
    .seg1      (seg1),
    .seg2      (seg2)
  );

  logic [6:0] seg_pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  ev_t        exp_q[$];

  // Reference model: the digits currently entered (last two kept), how many
  // cycles the submission still occupies, and idle cycles since the last digit.
  logic [3:0] digits[$];
  int         busy_left = 0;
  int         idle      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [7:0] model_code();
    if (digits.size() == 0) return 8'h00;
    if (digits.size() == 1) return {4'h0, digits[0]};
    return {digits[0], digits[1]};
  endfunction

  function automatic logic [6:0] model_seg(input int pos);
    logic [7:0] c;
    c = model_code();
    if (digits.size() <= pos) return 7'b1111111;
    return (pos == 0) ? seg_pat[c[3:0]] : seg_pat[c[7:4]];
  endfunction

  task automatic push_ev(input int kind, input logic [7:0] c, input int at);
    ev_t ev;
    ev.kind = kind;
    ev.code = c;
    ev.at   = at;
    exp_q.push_back(ev);
  endtask

  // Predict the effect of the upcoming clock edge, apply the key, then check state.
  task automatic step(input logic v, input logic [3:0] k);
    int e;
    e = cyc + 1;
    key_valid = v;
    key_code  = k;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        digits.delete();
        idle = 0;
      end
    end else if (v) begin
      if (k <= 4'd9) begin
        digits.push_back(k);
        if (digits.size() > 2) void'(digits.pop_front());
        idle = 0;
      end else if (k == 4'hA) begin
        digits.delete();
        idle = 0;
      end else if (k == 4'hB && digits.size() == 2) begin
        push_ev(EV_SUB, model_code(), e + 1);
        busy_left = OK_PULSE + 2;
        idle = 0;
      end else begin
        push_ev(EV_ERR, 8'h00, e);
      end
    end else if (digits.size() > 0) begin
      if (idle == TIMEOUT_CYCLES - 1) begin
        push_ev(EV_TMO, 8'h00, e);
        digits.delete();
        idle = 0;
      end else begin
        idle++;
      end
    end
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    chk("digit_cnt", digit_cnt, digits.size());
    chk("code", code, model_code());
    chk("busy", busy, busy_left > 0);
    chk("seg1", seg1, model_seg(0));
    chk("seg2", seg2, model_seg(1));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0);
  endtask

  task automatic drain_busy();
    for (int i = 0; i < 20 && busy_left > 0; i++) step(1'b0, 4'h0);
  endtask

  task automatic expect_event(input string name, input int kind, input logic [7:0] c);
    ev_t ev;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got event at cycle %0d code=%02h, required no event",
               name, cyc, c);
    end else begin
      ev = exp_q.pop_front();
      if (ev.kind != kind || ev.at != cyc || (kind == EV_SUB && ev.code !== c)) begin
        errors++;
        $display("FAIL event_%s: got kind=%0d cycle=%0d code=%02h, required kind=%0d cycle=%0d code=%02h",
                 name, kind, cyc, c, ev.kind, ev.at, ev.code);
      end
    end
  endtask

  // Monitor: drains the scoreboard on every output event and checks ok framing.
  logic       prev_ok = 1'b0;
  int         ok_w    = 0;
  logic [7:0] held    = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      prev_ok = 1'b0;
      ok_w    = 0;
    end else begin
      if (err)     expect_event("err", EV_ERR, 8'h00);
      if (timeout) expect_event("timeout", EV_TMO, 8'h00);
      if (ok && !prev_ok) begin
        expect_event("ok_rise", EV_SUB, code);
        held = code;
      end
      if (ok) begin
        ok_w++;
        chk("code_during_ok", code, held);
      end
      if (!ok && prev_ok) begin
        chk("ok_width", ok_w, OK_PULSE);
        chk("code_hold_after_ok", code, held);
        ok_w = 0;
      end
      prev_ok = ok;
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_ok"}, ok, 1'b0);
    chk({tag, "_code"}, code, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_digit_cnt"}, digit_cnt, 2'd0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_timeout"}, timeout, 1'b0);
    chk({tag, "_seg1"}, seg1, 7'b1111111);
    chk({tag, "_seg2"}, seg2, 7'b1111111);
  endtask

  initial begin
    int r;
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    // Submit 1,3 and watch the full frame.
    step(1'b1, 4'h1);
    step(1'b1, 4'h3);
    chk("seg2_after_13", seg2, 7'b1111001);
    chk("seg1_after_13", seg1, 7'b0110000);
    step(1'b1, 4'hB);
    drain_busy();

    // Early enter is rejected.
    step(1'b1, 4'h5);
    step(1'b1, 4'hB);
    chk("seg1_after_5", seg1, 7'b0010010);
    step(1'b1, 4'hA);

    // Last two digits win, keys during the pulse are dropped, illegal key errs.
    step(1'b1, 4'h9);
    step(1'b1, 4'h8);
    step(1'b1, 4'h7);
    step(1'b1, 4'hB);
    step(1'b0, 4'h0);
    step(1'b1, 4'h2);
    step(1'b1, 4'hA);
    drain_busy();
    step(1'b1, 4'hE);

    // Timeout after TIMEOUT_CYCLES idle cycles, then a key on the expiry cycle.
    step(1'b1, 4'h4);
    idle_steps(TIMEOUT_CYCLES);
    step(1'b1, 4'h4);
    idle_steps(TIMEOUT_CYCLES - 1);
    step(1'b1, 4'h6);
    step(1'b1, 4'hA);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       idle_steps($urandom_range(5, 12));
      else if (r < 40) step(1'b0, 4'($urandom_range(0, 15)));
      else if (r < 72) step(1'b1, 4'($urandom_range(0, 9)));
      else if (r < 84) step(1'b1, 4'hB);
      else if (r < 91) step(1'b1, 4'hA);
      else             step(1'b1, 4'($urandom_range(12, 15)));
    end
    idle_steps(20);

    // Reset asserted between edges in the middle of the ok pulse.
    step(1'b1, 4'hA);
    step(1'b1, 4'h6);
    step(1'b1, 4'h1);
    step(1'b1, 4'hB);
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    exp_q.delete();
    digits.delete();
    busy_left = 0;
    idle      = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 4'h2);
    step(1'b1, 4'h0);
    chk("code_after_reset_entry", code, 8'h20);
    step(1'b1, 4'hB);
    drain_busy();
    idle_steps(3);
    @(negedge clk);
    #1;

    chk("pending_events", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
